alu_result_stage: RTL

- Registered downstream stage for the combinational 64-bit ALU.
- Captures result, opcode tag and carry/zero/overflow flags into a 2-entry buffer, giving the ALU output a registered valid/ready interface toward the writeback logic.
- Keeps sticky carry/overflow status bits and a saturating count of retired operations for debug and perf readout.

---
 rtl/alu_result_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// Registered 2-entry output buffer behind the combinational 64-bit ALU.
// Adds valid/ready toward writeback, sticky carry/overflow and a retire count.
module alu_result_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int OPC_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [OPC_WIDTH-1:0]  inOpcode,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  carryFlag,
  input  logic                  zeroFlag,
  input  logic                  overFlowFlag,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [OPC_WIDTH-1:0]  outOpcode,
  output logic [DATA_WIDTH-1:0] outResult,
  output logic                  outCarry,
  output logic                  outZero,
  output logic                  outOverflow,
  output logic                  stickyCarry,
  output logic                  stickyOverflow,
  input  logic                  stickyClear,
  output logic [CNT_WIDTH-1:0]  opCount
);

  localparam int EW = OPC_WIDTH + DATA_WIDTH + 3;

  logic [EW-1:0]        r_mem [2];
  logic [EW-1:0]        r_hold;
  logic [1:0]           r_occ;
  logic                 r_wp;
  logic                 r_rp;
  logic                 r_sc;
  logic                 r_so;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_push;
  logic                 w_pop;
  logic [EW-1:0]        w_in;
  logic [EW-1:0]        w_head;

  assign inReady  = rst_n && (r_occ != 2'd2);
  assign outValid = (r_occ != 2'd0);
  assign w_push   = inValid && inReady;
  assign w_pop    = outValid && outReady;

  assign w_in = {inOpcode, result, carryFlag,
                 zeroFlag, overFlowFlag};

  // Empty buffer shows the last retired entry, not a stale slot
  assign w_head = outValid ? r_mem[r_rp] : r_hold;

  assign {outOpcode, outResult, outCarry,
          outZero, outOverflow} = w_head;

  assign stickyCarry    = r_sc;
  assign stickyOverflow = r_so;
  assign opCount        = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_hold   <= '0;
      r_occ    <= 2'd0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_in;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_hold <= r_mem[r_rp];
        r_rp   <= ~r_rp;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A flagged push in the same cycle as a clear keeps its flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc <= 1'b0;
      r_so <= 1'b0;
    end else if (w_push) begin
      r_sc <= (r_sc && !stickyClear) || carryFlag;
      r_so <= (r_so && !stickyClear) || overFlowFlag;
    end else if (stickyClear) begin
      r_sc <= 1'b0;
      r_so <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pop && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
